// File: rtl/player_move_ctrl_pkg.sv
// Shared game/resource constants and type encodings for the player movement controller.
package player_move_ctrl_pkg;

    // Game geometry
    localparam int unsigned MAP_WIDTH  = 13;
    localparam int unsigned MAP_HEIGHT = 13;
    localparam int unsigned NUM_MAPS   = 10;
    localparam int unsigned START_X    = 6;
    localparam int unsigned START_Y    = 11;

    // Resource tile ids
    localparam logic [15:0] TILE_WALL = 16'd1;
    localparam logic [15:0] TILE_UP   = 16'd2;
    localparam logic [15:0] TILE_DOWN = 16'd3;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWait,
        StDecide,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ResMoved     = 2'd0,
        ResBlocked   = 2'd1,
        ResFloorUp   = 2'd2,
        ResFloorDown = 2'd3
    } result_e;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        TileFloor,
        TileWall,
        TileUp,
        TileDown
    } tile_class_e;

endpackage

// File: rtl/player_move_ctrl_if.sv
// Move request/result handshake, map BRAM read port and player state outputs.
interface player_move_ctrl_if;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic [18:0] bRAM_map_addr;
    logic [15:0] bRAM_map_data;
    logic [3:0]  player_x;
    logic [3:0]  player_y;
    logic [18:0] map_id;
    logic        move_done;
    logic [1:0]  move_result;

    // Requester and BRAM side
    modport master (
        output move_valid, move_dir, bRAM_map_data,
        input  move_ready, bRAM_map_addr, player_x, player_y, map_id, move_done, move_result
    );

    // Controller side
    modport slave (
        input  move_valid, move_dir, bRAM_map_data,
        output move_ready, bRAM_map_addr, player_x, player_y, map_id, move_done, move_result
    );
endinterface

// File: rtl/player_move_ctrl_tile_classify.sv
// Combinational tile classifier: maps a 16-bit tile id onto floor/wall/stair classes.
module player_move_ctrl_tile_classify
    import player_move_ctrl_pkg::*;
(
    input  logic [15:0] tile,
    output tile_class_e tile_class
);

    always_comb begin
        tile_class = TileFloor;
        case (tile)
            TILE_WALL: tile_class = TileWall;
            TILE_UP:   tile_class = TileUp;
            TILE_DOWN: tile_class = TileDown;
            default:   tile_class = TileFloor;
        endcase
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: accepts one direction command at a time, looks up the target
// tile in the map BRAM and commits a step, a block or a floor change.
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input logic               clk,
    input logic               rstn,
    player_move_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(RD_LAT + 1);

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d;
    logic [3:0]      tx_q, tx_d, ty_q, ty_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     tile_q, tile_d;
    result_e         result_q, result_d;
    logic [18:0]     addr_q, addr_d;
    logic [3:0]      px_q, px_d, py_q, py_d;
    logic [18:0]     map_q, map_d;

    logic            oob;
    logic [18:0]     addr_calc;
    tile_class_e     tile_class;

    player_move_ctrl_tile_classify u_tile_classify (
        .tile       (tile_q),
        .tile_class (tile_class)
    );

    // Edge checks use the current position, so the wrapped target is never looked at.
    assign oob = (dir_q == DirLeft  && px_q == 4'd0) ||
                 (dir_q == DirUp    && py_q == 4'd0) ||
                 (dir_q == DirRight && px_q == 4'(MAP_WIDTH - 1)) ||
                 (dir_q == DirDown  && py_q == 4'(MAP_HEIGHT - 1));

    assign addr_calc = map_q * 19'(MAP_WIDTH * MAP_HEIGHT) + 19'(ty_q) * 19'(MAP_WIDTH)
                     + 19'(tx_q);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        cnt_d    = cnt_q;
        tile_d   = tile_q;
        result_d = result_q;
        addr_d   = addr_q;
        px_d     = px_q;
        py_d     = py_q;
        map_d    = map_q;

        case (state_q)
            StIdle: begin
                if (bus.move_valid) begin
                    dir_d = dir_e'(bus.move_dir);
                    tx_d  = px_q;
                    ty_d  = py_q;
                    unique case (dir_e'(bus.move_dir))
                        DirUp:    ty_d = py_q - 4'd1;
                        DirDown:  ty_d = py_q + 4'd1;
                        DirLeft:  tx_d = px_q - 4'd1;
                        DirRight: tx_d = px_q + 4'd1;
                    endcase
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (oob) begin
                    result_d = ResBlocked;
                    state_d  = StDone;
                end else begin
                    addr_d  = addr_calc;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == CntW'(RD_LAT)) begin
                    tile_d  = bus.bRAM_map_data;
                    state_d = StDecide;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecide: begin
                unique case (tile_class)
                    TileWall: result_d = ResBlocked;
                    TileUp: begin
                        if (map_q < 19'(NUM_MAPS - 1)) begin
                            map_d    = map_q + 19'd1;
                            result_d = ResFloorUp;
                        end else begin
                            result_d = ResBlocked;
                        end
                    end
                    TileDown: begin
                        if (map_q != 19'd0) begin
                            map_d    = map_q - 19'd1;
                            result_d = ResFloorDown;
                        end else begin
                            result_d = ResBlocked;
                        end
                    end
                    TileFloor: begin
                        px_d     = tx_q;
                        py_d     = ty_q;
                        result_d = ResMoved;
                    end
                endcase
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            dir_q    <= DirUp;
            tx_q     <= '0;
            ty_q     <= '0;
            cnt_q    <= '0;
            tile_q   <= '0;
            result_q <= ResMoved;
            addr_q   <= '0;
            px_q     <= 4'(START_X);
            py_q     <= 4'(START_Y);
            map_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            cnt_q    <= cnt_d;
            tile_q   <= tile_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            px_q     <= px_d;
            py_q     <= py_d;
            map_q    <= map_d;
        end
    end

    assign bus.move_ready    = (state_q == StIdle);
    assign bus.move_done     = (state_q == StDone);
    assign bus.move_result   = result_q;
    assign bus.bRAM_map_addr = addr_q;
    assign bus.player_x      = px_q;
    assign bus.player_y      = py_q;
    assign bus.map_id        = map_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a two-cycle-latency map BRAM model.
module tb_player_move_ctrl;

    localparam int MapCells = 13 * 13;
    localparam int MemSize  = 10 * MapCells;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [15:0] mem [MemSize];
    logic [15:0] rd_d1, rd_d2;

    player_move_ctrl_if bus ();

    player_move_ctrl #(.RD_LAT(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_d1 <= (int'(bus.bRAM_map_addr) < MemSize) ? mem[int'(bus.bRAM_map_addr)] : 16'd0;
        rd_d2 <= rd_d1;
    end
    assign bus.bRAM_map_data = rd_d2;

    function automatic int idx(input int m, input int x, input int y);
        return m * MapCells + y * 13 + x;
    endfunction

    task automatic do_move(input logic [1:0] dir, output logic [1:0] res, output int lat);
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_dir   = dir;
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        lat = 1;
        while (bus.move_done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.move_done !== 1'b1) lat = -1;
        res = bus.move_result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks += 7;
        if (bus.player_x !== 4'd6) begin n_fail++; $display("FAIL reset_x: got %0d expected 6", bus.player_x); end
        if (bus.player_y !== 4'd11) begin n_fail++; $display("FAIL reset_y: got %0d expected 11", bus.player_y); end
        if (bus.map_id !== 19'd0) begin n_fail++; $display("FAIL reset_map: got %0d expected 0", bus.map_id); end
        if (bus.move_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.move_ready); end
        if (bus.move_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.move_done); end
        if (bus.move_result !== 2'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", bus.move_result); end
        if (bus.bRAM_map_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.bRAM_map_addr); end
    endtask

    task automatic test_move_floor();
        logic [1:0] res; int lat;
        do_move(2'd3, res, lat);
        n_checks += 5;
        if (lat != 6) begin n_fail++; $display("FAIL floor_latency: got %0d expected 6", lat); end
        if (res !== 2'd0) begin n_fail++; $display("FAIL floor_result: got %0d expected 0", res); end
        if (bus.player_x !== 4'd7) begin n_fail++; $display("FAIL floor_x: got %0d expected 7", bus.player_x); end
        if (bus.player_y !== 4'd11) begin n_fail++; $display("FAIL floor_y: got %0d expected 11", bus.player_y); end
        if (bus.bRAM_map_addr !== 19'd150) begin n_fail++; $display("FAIL floor_addr: got %0d expected 150", bus.bRAM_map_addr); end
    endtask

    task automatic test_wall();
        logic [1:0] res; int lat;
        mem[idx(0, 7, 10)] = 16'd1;
        do_move(2'd0, res, lat);
        n_checks += 4;
        if (res !== 2'd1) begin n_fail++; $display("FAIL wall_result: got %0d expected 1", res); end
        if (bus.player_x !== 4'd7 || bus.player_y !== 4'd11) begin
            n_fail++; $display("FAIL wall_pos: got (%0d,%0d) expected (7,11)", bus.player_x, bus.player_y);
        end
        if (bus.map_id !== 19'd0) begin n_fail++; $display("FAIL wall_map: got %0d expected 0", bus.map_id); end
        if (bus.bRAM_map_addr !== 19'd137) begin n_fail++; $display("FAIL wall_addr: got %0d expected 137", bus.bRAM_map_addr); end
    endtask

    task automatic test_stairs();
        logic [1:0] res; int lat;
        mem[idx(0, 8, 11)] = 16'd2;
        do_move(2'd3, res, lat);
        n_checks += 3;
        if (res !== 2'd2) begin n_fail++; $display("FAIL up_result: got %0d expected 2", res); end
        if (bus.map_id !== 19'd1) begin n_fail++; $display("FAIL up_map: got %0d expected 1", bus.map_id); end
        if (bus.player_x !== 4'd7 || bus.player_y !== 4'd11) begin
            n_fail++; $display("FAIL up_pos: got (%0d,%0d) expected (7,11)", bus.player_x, bus.player_y);
        end
        mem[idx(1, 7, 10)] = 16'd3;
        do_move(2'd0, res, lat);
        n_checks += 2;
        if (res !== 2'd3) begin n_fail++; $display("FAIL down_result: got %0d expected 3", res); end
        if (bus.map_id !== 19'd0) begin n_fail++; $display("FAIL down_map: got %0d expected 0", bus.map_id); end
        mem[idx(0, 6, 11)] = 16'd3;
        do_move(2'd2, res, lat);
        n_checks += 3;
        if (res !== 2'd1) begin n_fail++; $display("FAIL down_floor0_result: got %0d expected 1", res); end
        if (bus.map_id !== 19'd0) begin n_fail++; $display("FAIL down_floor0_map: got %0d expected 0", bus.map_id); end
        if (bus.player_x !== 4'd7) begin n_fail++; $display("FAIL down_floor0_x: got %0d expected 7", bus.player_x); end
        mem[idx(0, 6, 11)] = 16'd0;
        mem[idx(1, 7, 10)] = 16'd0;
        for (int k = 0; k < 9; k++) mem[idx(k, 8, 11)] = 16'd2;
        for (int k = 0; k < 9; k++) begin
            do_move(2'd3, res, lat);
            n_checks++;
            if (res !== 2'd2) begin n_fail++; $display("FAIL climb_result[%0d]: got %0d expected 2", k, res); end
        end
        n_checks++;
        if (bus.map_id !== 19'd9) begin n_fail++; $display("FAIL climb_map: got %0d expected 9", bus.map_id); end
        mem[idx(9, 8, 11)] = 16'd2;
        do_move(2'd3, res, lat);
        n_checks += 2;
        if (res !== 2'd1) begin n_fail++; $display("FAIL top_result: got %0d expected 1", res); end
        if (bus.map_id !== 19'd9) begin n_fail++; $display("FAIL top_map: got %0d expected 9", bus.map_id); end
        for (int k = 4; k < 10; k++) mem[idx(k, 6, 11)] = 16'd3;
        for (int k = 0; k < 6; k++) begin
            do_move(2'd2, res, lat);
            n_checks++;
            if (res !== 2'd3) begin n_fail++; $display("FAIL descend_result[%0d]: got %0d expected 3", k, res); end
        end
        n_checks++;
        if (bus.map_id !== 19'd3) begin n_fail++; $display("FAIL descend_map: got %0d expected 3", bus.map_id); end
    endtask

    task automatic test_addr();
        logic [1:0] res; int lat;
        mem[idx(3, 8, 11)] = 16'd0;
        for (int k = 0; k < 15; k++) begin
            do_move((k < 5) ? 2'd3 : 2'd0, res, lat);
            n_checks++;
            if (res !== 2'd0) begin n_fail++; $display("FAIL walk_result[%0d]: got %0d expected 0", k, res); end
        end
        do_move(2'd0, res, lat);
        n_checks += 3;
        if (res !== 2'd0) begin n_fail++; $display("FAIL addr_result: got %0d expected 0", res); end
        if (bus.bRAM_map_addr !== 19'd519) begin n_fail++; $display("FAIL addr_value: got %0d expected 519", bus.bRAM_map_addr); end
        if (bus.player_x !== 4'd12 || bus.player_y !== 4'd0) begin
            n_fail++; $display("FAIL addr_pos: got (%0d,%0d) expected (12,0)", bus.player_x, bus.player_y);
        end
    endtask

    task automatic test_oob_corner();
        logic [1:0] res; int lat;
        logic [1:0] dirs [2];
        dirs[0] = 2'd0;
        dirs[1] = 2'd3;
        for (int k = 0; k < 2; k++) begin
            do_move(dirs[k], res, lat);
            n_checks += 4;
            if (lat != 2) begin n_fail++; $display("FAIL oob_latency[%0d]: got %0d expected 2", k, lat); end
            if (res !== 2'd1) begin n_fail++; $display("FAIL oob_result[%0d]: got %0d expected 1", k, res); end
            if (bus.bRAM_map_addr !== 19'd519) begin n_fail++; $display("FAIL oob_addr[%0d]: got %0d expected 519", k, bus.bRAM_map_addr); end
            if (bus.player_x !== 4'd12 || bus.player_y !== 4'd0) begin
                n_fail++; $display("FAIL oob_pos[%0d]: got (%0d,%0d) expected (12,0)", k, bus.player_x, bus.player_y);
            end
        end
    endtask

    task automatic test_ignore();
        int n_done = 0;
        int early_ready = 0;
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'd2;
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'd1;
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.move_done === 1'b1) n_done++;
            else if (n_done == 0 && bus.move_ready !== 1'b0) early_ready++;
            @(posedge clk); #1;
        end
        n_checks += 4;
        if (n_done != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
        if (early_ready != 0) begin n_fail++; $display("FAIL ignore_ready_busy: got %0d ready cycles expected 0", early_ready); end
        if (bus.player_x !== 4'd11 || bus.player_y !== 4'd0) begin
            n_fail++; $display("FAIL ignore_pos: got (%0d,%0d) expected (11,0)", bus.player_x, bus.player_y);
        end
        if (bus.move_ready !== 1'b1) begin n_fail++; $display("FAIL ignore_ready_idle: got %b expected 1", bus.move_ready); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] res; int lat;
        int n_done = 0;
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'd1;
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        n_checks += 5;
        if (bus.player_x !== 4'd6 || bus.player_y !== 4'd11) begin
            n_fail++; $display("FAIL midrst_pos: got (%0d,%0d) expected (6,11)", bus.player_x, bus.player_y);
        end
        if (bus.map_id !== 19'd0) begin n_fail++; $display("FAIL midrst_map: got %0d expected 0", bus.map_id); end
        if (bus.move_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.move_done); end
        if (bus.bRAM_map_addr !== 19'd0) begin n_fail++; $display("FAIL midrst_addr: got %0d expected 0", bus.bRAM_map_addr); end
        if (bus.move_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", bus.move_ready); end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.move_done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", n_done); end
        do_move(2'd2, res, lat);
        n_checks += 3;
        if (lat != 6) begin n_fail++; $display("FAIL postrst_latency: got %0d expected 6", lat); end
        if (res !== 2'd0) begin n_fail++; $display("FAIL postrst_result: got %0d expected 0", res); end
        if (bus.player_x !== 4'd5 || bus.player_y !== 4'd11) begin
            n_fail++; $display("FAIL postrst_pos: got (%0d,%0d) expected (5,11)", bus.player_x, bus.player_y);
        end
    endtask

    task automatic test_left_edge();
        logic [1:0] res; int lat;
        for (int k = 0; k < 5; k++) do_move(2'd2, res, lat);
        n_checks += 2;
        if (bus.player_x !== 4'd0) begin n_fail++; $display("FAIL edge_walk_x: got %0d expected 0", bus.player_x); end
        if (bus.bRAM_map_addr !== 19'd143) begin n_fail++; $display("FAIL edge_walk_addr: got %0d expected 143", bus.bRAM_map_addr); end
        do_move(2'd2, res, lat);
        n_checks += 4;
        if (lat != 2) begin n_fail++; $display("FAIL edge_latency: got %0d expected 2", lat); end
        if (res !== 2'd1) begin n_fail++; $display("FAIL edge_result: got %0d expected 1", res); end
        if (bus.bRAM_map_addr !== 19'd143) begin n_fail++; $display("FAIL edge_addr: got %0d expected 143", bus.bRAM_map_addr); end
        if (bus.player_x !== 4'd0 || bus.player_y !== 4'd11) begin
            n_fail++; $display("FAIL edge_pos: got (%0d,%0d) expected (0,11)", bus.player_x, bus.player_y);
        end
    endtask

    initial begin
        for (int i = 0; i < MemSize; i++) mem[i] = 16'd0;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #20;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        test_move_floor();
        test_wall();
        test_stairs();
        test_addr();
        test_oob_corner();
        test_ignore();
        test_reset_mid();
        test_left_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
